// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel run-time programmable 50% clock divider with glitch-free ratio/stop changes
// Ports: clk_in/rst (async, active-high) | en per-channel run enable | div_load/div_sel/div_val
//        half-period write strobe, target and value | clk_out divided clocks | tick rising-edge
//        pulse | running channel active (RUN or STOPPING)
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_load,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [CNT_W-1:0]    div_val,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] running
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  logic [CNT_W-1:0] w_val;
  assign w_val = div_val == '0 ? CNT_W'(1) : div_val;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t r_state, w_next;
    logic [CNT_W-1:0] r_cnt, r_act, r_shd, w_cnt, w_act, w_shd;
    logic r_pend, r_clk, r_tick, r_run, w_pend, w_clk, w_tick, w_bnd, w_ld;
    // out-of-range selects match no channel, so they are dropped here
    assign w_ld = div_load && div_sel == SEL_W'(c);
    always_comb begin
      w_bnd = r_state != IDLE && r_cnt == r_act - 1'b1;
      w_next = r_state;
      w_cnt = r_cnt;
      w_clk = r_clk;
      w_tick = 1'b0;
      if (r_state == IDLE) begin
        w_cnt = '0;
        w_clk = 1'b0;
        w_next = en[c] ? RUN : IDLE;
      end else if (!en[c] && !r_clk) begin
        // stopping while low needs no phase completion; suppresses the pending rise
        w_cnt = '0;
        w_clk = 1'b0;
        w_next = IDLE;
      end else begin
        w_cnt = w_bnd ? '0 : r_cnt + 1'b1;
        w_clk = r_clk ^ w_bnd;
        w_tick = w_bnd & ~r_clk;
        w_next = en[c] ? RUN : w_bnd ? IDLE : STOPPING;
      end
      w_act = r_act;
      w_shd = r_shd;
      w_pend = r_pend;
      // a pending ratio lands at a phase boundary, or at once if the channel went idle first
      if (r_pend && (w_bnd || r_state == IDLE)) begin
        w_act = r_shd;
        w_pend = 1'b0;
      end
      // a load coinciding with a boundary stays pending for the following boundary
      if (w_ld) begin
        w_shd = w_val;
        if (r_state == IDLE) w_act = w_val;
        else w_pend = 1'b1;
      end
    end
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_clk <= 1'b0;
        r_tick <= 1'b0;
        r_run <= 1'b0;
        r_act <= CNT_W'(DEFAULT_DIV);
        r_shd <= CNT_W'(DEFAULT_DIV);
        r_pend <= 1'b0;
      end else begin
        r_state <= w_next;
        r_cnt <= w_cnt;
        r_clk <= w_clk;
        r_tick <= w_tick;
        r_run <= w_next != IDLE;
        r_act <= w_act;
        r_shd <= w_shd;
        r_pend <= w_pend;
      end
    end
    assign clk_out[c] = r_clk;
    assign tick[c] = r_tick;
    assign running[c] = r_run;
  end
endmodule
